// File: rtl/sb_pkg.sv
// Shared sideband definitions: TX FSM states and default link constants
// used by both the TX serializer and the RX deserializer.
package sb_pkg;

  localparam int unsigned SB_MSG_W_DEF  = 64;
  localparam int unsigned SB_GAP_UI_DEF = 32;

  typedef enum logic [1:0] {SB_IDLE, SB_SHIFT, SB_GAP} sb_tx_state_t;

  function automatic int unsigned sb_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Synchronous FIFO with first-word fall-through read data (valid in the pop cycle).
// DEPTH must be a power of two so the pointers wrap naturally.
module sb_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

endmodule

// File: rtl/sb_tx_serializer.sv
// Sideband TX: buffers messages, shifts them out MSB-first with a gated forwarded
// clock and a fixed idle gap. Define SB_TX_PARITY_EN to append an even-parity UI.
module sb_tx_serializer
  import sb_pkg::*;
#(
  parameter int unsigned MSG_W  = SB_MSG_W_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned GAP_UI = SB_GAP_UI_DEF
) (
  input  logic                       clk_800MHz,
  input  logic                       reset,
  input  logic                       enable_i,
  input  logic [MSG_W-1:0]           data_i,
  input  logic                       valid_i,
  output logic                       data_valid_ack_o,
  output logic                       dataPin_o,
  output logic                       clkPin_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level_o
);

`ifdef SB_TX_PARITY_EN
  localparam int unsigned PKT_UI = MSG_W + 1;
`else
  localparam int unsigned PKT_UI = MSG_W;
`endif
  localparam int unsigned CNT_W = $clog2(sb_max(PKT_UI, GAP_UI) + 1);

  sb_tx_state_t     state_q, state_n;
  logic [MSG_W-1:0] sreg_q, sreg_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             data_q, data_n;
  logic             clk_q, clk_n;
  logic             busy_q;
  logic             pop;
  logic             full;
  logic             empty;
  logic [MSG_W-1:0] head;
  logic             ui_bit;

  assign data_valid_ack_o = valid_i & ~full;

  sb_fifo #(.W(MSG_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_800MHz),
    .rst_n (reset),
    .push  (data_valid_ack_o),
    .wdata (data_i),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level_o)
  );

`ifdef SB_TX_PARITY_EN
  logic parity_q;

  // Parity is latched at pop because the shift register is consumed by the time it is sent.
  always_ff @(posedge clk_800MHz) begin
    if (!reset)   parity_q <= 1'b0;
    else if (pop) parity_q <= ^head;
  end

  assign ui_bit = (cnt_q == CNT_W'(MSG_W)) ? parity_q : sreg_q[MSG_W-1];
`else
  assign ui_bit = sreg_q[MSG_W-1];
`endif

  // Next-state, shift/count and output-bit logic.
  always_comb begin
    state_n = state_q;
    sreg_n  = sreg_q;
    cnt_n   = cnt_q;
    data_n  = 1'b0;
    clk_n   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      SB_IDLE: begin
        if (enable_i && !empty) begin
          state_n = SB_SHIFT;
          pop     = 1'b1;
          sreg_n  = head;
          cnt_n   = '0;
        end
      end
      SB_SHIFT: begin
        data_n = ui_bit;
        clk_n  = 1'b1;
        sreg_n = {sreg_q[MSG_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(PKT_UI - 1)) begin
          state_n = SB_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      SB_GAP: begin
        if (cnt_q == CNT_W'(GAP_UI - 1)) begin
          cnt_n = '0;
          // Chain straight into the next packet so back-to-back traffic has no idle cycle.
          if (enable_i && !empty) begin
            state_n = SB_SHIFT;
            pop     = 1'b1;
            sreg_n  = head;
          end else begin
            state_n = SB_IDLE;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk_800MHz) begin
    if (!reset) begin
      state_q <= SB_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      clk_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sreg_q  <= sreg_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      clk_q   <= clk_n;
      busy_q  <= (state_n != SB_IDLE);
    end
  end

  assign dataPin_o = data_q;
  assign clkPin_o  = clk_q;
  assign busy_o    = busy_q;

endmodule
